// File: rtl/serial_transceiver.sv
// UART-style transceiver: parity-capable transmitter, mid-bit sampling receiver
// and a first-word-fall-through receive FIFO carrying per-word error flags.
//
// state  | meaning (TX and RX share names; BREAK is RX only)
// IDLE   | line idle; TX accepts a character, RX waits for a low
// START  | start bit; RX resamples at half a bit to reject glitches
// DATA   | data bits, LSB first
// PARITY | parity bit (skipped when PARITY = 0)
// STOP   | stop bit(s); RX writes the word on the first stop sample
// BREAK  | RX saw a low stop bit, waits for the line to return high
module serial_transceiver #(
    parameter int DATA_BITS     = 8,
    parameter int CLKS_PER_BIT  = 16,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               txd,
    input  logic                               rxd,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rx_valid,
    input  logic                               rx_read,
    output logic                               parity_err,
    output logic                               frame_err,
    output logic                               overrun,
    output logic [$clog2(RX_FIFO_DEPTH):0]     rx_count
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    localparam logic [TW-1:0] T_BIT   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
    localparam logic [PW:0]   FULL    = (PW + 1)'(RX_FIFO_DEPTH);
    localparam logic          ODD     = (PARITY == 2);
    localparam logic          HAS_PAR = (PARITY != 0);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    tx_state_t            tx_state, tx_state_nxt;
    logic [TW-1:0]        tx_timer;
    logic [BW-1:0]        tx_bit_cnt;
    logic                 tx_stop_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_tc;
    logic                 tx_accept;

    assign tx_tc     = (tx_timer == '0);
    assign tx_accept = tx_valid && (tx_state == TX_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_ready     = 1'b0;
        txd          = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) tx_state_nxt = TX_START;
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_tc) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_shift[0];
                if (tx_tc && (tx_bit_cnt == '0))
                    tx_state_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                txd = tx_par;
                if (tx_tc) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tc && !tx_stop_cnt) tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // One down-counter times every bit; it reloads on terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_timer    <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
        end else if (tx_accept) begin
            tx_shift    <= tx_data;
            tx_par      <= (^tx_data) ^ ODD;
            tx_timer    <= T_BIT;
            tx_bit_cnt  <= B_LAST;
            tx_stop_cnt <= 1'(STOP_BITS - 1);
        end else if (tx_state != TX_IDLE) begin
            tx_timer <= tx_tc ? T_BIT : tx_timer - 1'b1;
            if (tx_tc && (tx_state == TX_DATA)) begin
                tx_shift   <= tx_shift >> 1;
                tx_bit_cnt <= tx_bit_cnt - 1'b1;
            end
            if (tx_tc && (tx_state == TX_STOP)) tx_stop_cnt <= 1'b0;
        end
    end

    rx_state_t            rx_state, rx_state_nxt;
    logic [1:0]           rx_sync;
    logic                 rxs;
    logic [TW-1:0]        rx_timer;
    logic [BW-1:0]        rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_tc;
    logic                 fifo_wr;
    logic                 wr_perr;
    logic                 wr_ferr;

    assign rxs     = rx_sync[1];
    assign rx_tc   = (rx_timer == '0);
    assign wr_perr = HAS_PAR && ((^rx_shift) ^ rx_par_bit ^ ODD);
    assign wr_ferr = !rxs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        fifo_wr      = 1'b0;
        case (rx_state)
            RX_IDLE:   if (!rxs) rx_state_nxt = RX_START;
            RX_START:  if (rx_tc) rx_state_nxt = rxs ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_tc && (rx_bit_cnt == '0))
                    rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_tc) rx_state_nxt = RX_STOP;
            RX_STOP: begin
                if (rx_tc) begin
                    fifo_wr      = 1'b1;
                    rx_state_nxt = rxs ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK:  if (rxs) rx_state_nxt = RX_IDLE;
            default:   rx_state_nxt = RX_IDLE;
        endcase
    end

    // IDLE keeps the timer primed with half a bit so START lands mid-bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_timer   <= '0;
            rx_bit_cnt <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            rx_timer   <= T_HALF;
            rx_bit_cnt <= B_LAST;
        end else if (rx_state != RX_BREAK) begin
            rx_timer <= rx_tc ? T_BIT : rx_timer - 1'b1;
            if (rx_tc && (rx_state == RX_DATA)) begin
                rx_shift   <= {rxs, rx_shift[DATA_BITS-1:1]};
                rx_bit_cnt <= rx_bit_cnt - 1'b1;
            end
            if (rx_tc && (rx_state == RX_PARITY)) rx_par_bit <= rxs;
        end
    end

    logic [DATA_BITS-1:0] fifo_data [RX_FIFO_DEPTH];
    logic                 fifo_perr [RX_FIFO_DEPTH];
    logic                 fifo_ferr [RX_FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count;
    logic                 fifo_rd;
    logic                 fifo_wr_ok;

    assign fifo_rd    = rx_read && (count != '0);
    // A read in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign fifo_wr_ok = fifo_wr && ((count != FULL) || fifo_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (fifo_wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd)    rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr_ok, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fifo_wr && !fifo_wr_ok) overrun <= 1'b1;
            else if (fifo_rd)           overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr_ok) begin
            fifo_data[wr_ptr] <= rx_shift;
            fifo_perr[wr_ptr] <= wr_perr;
            fifo_ferr[wr_ptr] <= wr_ferr;
        end
    end

    assign rx_valid   = (count != '0);
    assign rx_count   = count;
    assign rx_data    = rx_valid ? fifo_data[rd_ptr] : '0;
    assign parity_err = rx_valid && fifo_perr[rd_ptr];
    assign frame_err  = rx_valid && fifo_ferr[rd_ptr];

endmodule

// File: tb/tb_serial_transceiver.sv
// Self-checking bench for serial_transceiver: frame-level TX waveform model,
// word-queue RX/FIFO model, randomized traffic plus fixed literal cases.
module tb_serial_transceiver;

    localparam int DB    = 8;
    localparam int CPB   = 16;
    localparam int PAR   = 1;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
    localparam int FRAME = (1 + DB + 1 + SB) * CPB;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       rxd;
    logic       rxd_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_read = 1'b0;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic [2:0] rx_count;

    int n_chk = 0;
    int n_pass = 0;

    logic  tx_exp [$];
    word_t mq [$];
    logic  m_ovr = 1'b0;
    logic  wave [0:399];

    always #5 clk = ~clk;

    assign rxd = loop_en ? txd : rxd_drv;

    serial_transceiver #(
        .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(PAR),
        .STOP_BITS(SB), .RX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .rxd(rxd), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_read(rx_read), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .rx_count(rx_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected line waveform for one character, one entry per clock.
    task automatic push_tx_frame(input logic [7:0] d);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (PAR != 0) bits.push_back((^d) ^ (PAR == 2));
        for (int i = 0; i < SB; i++) bits.push_back(1'b1);
        foreach (bits[i]) for (int k = 0; k < CPB; k++) tx_exp.push_back(bits[i]);
    endtask

    always @(negedge clk) begin
        logic b;
        if (!reset_n) begin
            tx_exp.delete();
        end else begin
            if (tx_exp.size() > 0) begin
                b = tx_exp.pop_front();
                chk("txd_bit", int'(txd), int'(b));
                chk("tx_ready_busy", int'(tx_ready), 0);
            end else begin
                chk("txd_idle", int'(txd), 1);
                chk("tx_ready_idle", int'(tx_ready), 1);
            end
            if (tx_valid && tx_ready) push_tx_frame(tx_data);
        end
    end

    task automatic model_rx(input logic [7:0] d, input logic pe, input logic fe);
        word_t w;
        w.d = d; w.pe = pe; w.fe = fe;
        if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(w);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, int'(rx_count), mq.size());
        chk({tag, "_valid"}, int'(rx_valid), int'(mq.size() != 0));
        chk({tag, "_overrun"}, int'(overrun), int'(m_ovr));
        if (mq.size() == 0) begin
            chk({tag, "_data_empty"}, int'(rx_data), 0);
            chk({tag, "_perr_empty"}, int'(parity_err), 0);
            chk({tag, "_ferr_empty"}, int'(frame_err), 0);
        end else begin
            chk({tag, "_data"}, int'(rx_data), int'(mq[0].d));
            chk({tag, "_perr"}, int'(parity_err), int'(mq[0].pe));
            chk({tag, "_ferr"}, int'(frame_err), int'(mq[0].fe));
        end
    endtask

    task automatic rx_pop(input string tag);
        word_t w;
        check_rx(tag);
        rx_read = 1'b1;
        @(posedge clk); #1;
        rx_read = 1'b0;
        if (mq.size() > 0) begin
            w = mq.pop_front();
            m_ovr = 1'b0;
        end
        check_rx({tag, "_after"});
    endtask

    task automatic tx_send(input logic [7:0] d);
        int b = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && b < 1000) begin @(posedge clk); #1; b++; end
        if (b >= 1000) chk("tx_accept_timeout", int'(tx_ready), 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int b = 0;
        while (!tx_ready && b < 1000) begin @(posedge clk); #1; b++; end
        if (b >= 1000) chk("tx_idle_timeout", int'(tx_ready), 1);
    endtask

    task automatic rx_drive(input logic [7:0] d, input logic bad_par,
                            input logic bad_stop, input int hold_low);
        logic [10:0] bits;
        bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd_drv = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (hold_low > 0) begin
            rxd_drv = 1'b0;
            repeat (hold_low) @(posedge clk);
            #1;
        end
        rxd_drv = 1'b1;
        model_rx(d, bad_par, bad_stop);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [10:0] exp07;
        logic [7:0]  d;
        logic [7:0]  dq [2];
        int          n;
        logic        bp, bs;

        idle_cycles(3);
        chk("reset_txd", int'(txd), 1);
        chk("reset_tx_ready", int'(tx_ready), 1);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_rx_count", int'(rx_count), 0);
        chk("reset_perr", int'(parity_err), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        idle_cycles(3);

        // 0x07 with even parity: literal waveform and frame length
        tx_send(8'h07);
        cyc = 0;
        while (!tx_ready && cyc < 400) begin
            wave[cyc] = txd;
            @(posedge clk); #1;
            cyc++;
        end
        chk("tx07_frame_cycles", cyc, 176);
        exp07 = 11'b11000001110;
        for (int i = 0; i < 11; i++) chk("tx07_bit", int'(wave[8 + 16 * i]), int'(exp07[i]));
        idle_cycles(5);

        // loopback back-to-back 0x55, 0xA3
        loop_en = 1'b1;
        tx_send(8'h55);
        tx_send(8'hA3);
        wait_tx_idle();
        idle_cycles(4);
        model_rx(8'h55, 1'b0, 1'b0);
        model_rx(8'hA3, 1'b0, 1'b0);
        chk("loop_count_lit", int'(rx_count), 2);
        chk("loop_first_lit", int'(rx_data), 8'h55);
        rx_pop("loop_w0");
        chk("loop_second_lit", int'(rx_data), 8'hA3);
        rx_pop("loop_w1");
        loop_en = 1'b0;
        idle_cycles(5);

        // low stop bit, line held low for two frame times: only one word
        rx_drive(8'h3C, 1'b0, 1'b1, 2 * FRAME);
        idle_cycles(4);
        chk("break_ferr_lit", int'(frame_err), 1);
        chk("break_data_lit", int'(rx_data), 8'h3C);
        chk("break_count_lit", int'(rx_count), 1);
        rx_pop("break_w");
        idle_cycles(6);
        rx_drive(8'hC9, 1'b0, 1'b0, 0);
        check_rx("after_break");
        rx_pop("after_break_pop");

        // inverted parity
        idle_cycles(6);
        rx_drive(8'h3C, 1'b1, 1'b0, 0);
        chk("perr_lit", int'(parity_err), 1);
        chk("perr_data_lit", int'(rx_data), 8'h3C);
        chk("perr_ferr_lit", int'(frame_err), 0);
        rx_pop("perr_w");

        // five words into a depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            idle_cycles($urandom_range(3, 12));
            d = 8'($urandom);
            rx_drive(d, 1'b0, 1'b0, 0);
        end
        check_rx("ovr_full");
        chk("ovr_count_lit", int'(rx_count), 4);
        chk("ovr_flag_lit", int'(overrun), 1);
        rx_pop("ovr_pop0");
        chk("ovr_clear_lit", int'(overrun), 0);
        for (int i = 0; i < 3; i++) rx_pop("ovr_drain");

        // randomized mix of loopback and directly driven frames
        for (int it = 0; it < 14; it++) begin
            idle_cycles($urandom_range(3, 20));
            if ($urandom_range(0, 1) == 1) begin
                loop_en = 1'b1;
                n = $urandom_range(1, 2);
                for (int k = 0; k < n; k++) begin
                    dq[k] = 8'($urandom);
                    tx_send(dq[k]);
                end
                wait_tx_idle();
                idle_cycles(4);
                for (int k = 0; k < n; k++) model_rx(dq[k], 1'b0, 1'b0);
                loop_en = 1'b0;
            end else begin
                d  = 8'($urandom);
                bp = ($urandom_range(0, 3) == 0);
                bs = ($urandom_range(0, 4) == 0);
                rx_drive(d, bp, bs, 0);
            end
            check_rx("rand");
            if ($urandom_range(0, 2) != 0) rx_pop("rand_pop");
        end
        while (mq.size() > 0) rx_pop("rand_drain");
        idle_cycles(4);

        // read on empty, then a 5-cycle glitch
        rx_pop("empty_read");
        rxd_drv = 1'b0;
        idle_cycles(5);
        rxd_drv = 1'b1;
        idle_cycles(40);
        chk("false_start_count_lit", int'(rx_count), 0);
        check_rx("false_start");
        rx_drive(8'h81, 1'b0, 1'b0, 0);
        check_rx("after_false_start");
        rx_pop("after_false_start_pop");

        // reset in the middle of a looped-back frame
        idle_cycles(5);
        rx_drive(8'h5A, 1'b0, 1'b0, 0);
        loop_en = 1'b1;
        tx_send(8'($urandom));
        idle_cycles(60);
        reset_n = 1'b0;
        #1;
        chk("midreset_txd", int'(txd), 1);
        chk("midreset_tx_ready", int'(tx_ready), 1);
        chk("midreset_rx_valid", int'(rx_valid), 0);
        chk("midreset_rx_count", int'(rx_count), 0);
        chk("midreset_overrun", int'(overrun), 0);
        mq.delete();
        m_ovr = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_cycles(FRAME + 20);
        check_rx("post_reset");
        tx_send(8'h96);
        wait_tx_idle();
        idle_cycles(4);
        model_rx(8'h96, 1'b0, 1'b0);
        chk("post_reset_data_lit", int'(rx_data), 8'h96);
        rx_pop("post_reset_pop");
        loop_en = 1'b0;
        idle_cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
